// File: rtl/init_seq_pkg.sv
// Shared types and widths for the init/reset sequencer.
package init_seq_pkg;

  // Stability and release-gap counter width
  localparam int unsigned CntW = 16;
  // Init wait timer width
  localparam int unsigned TimerW = 32;

  typedef enum logic [1:0] {
    StWaitInit,
    StRelease,
    StRun,
    StFault
  } seq_state_e;

endpackage

// File: rtl/init_done_filter.sv
// Per-channel init-done synchroniser with a saturating stability counter.
module init_done_filter
  import init_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init_done,
  output logic synced,
  output logic stable
);

  localparam logic [CntW-1:0] StableVal = CntW'(STABLE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CntW-1:0]        cnt_q, cnt_d;

  // Synchroniser chain for the asynchronous done flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], init_done};
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // Count consecutive synced-high cycles, saturating at the threshold
  always_comb begin
    cnt_d = cnt_q;
    if (!synced)                cnt_d = '0;
    else if (cnt_q != StableVal) cnt_d = cnt_q + 1'b1;
  end

  // Stability counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign stable = (cnt_q == StableVal);

endmodule

// File: rtl/init_reset_sequencer.sv
// Waits for filtered init-done flags, then releases per-channel resets in order.
module init_reset_sequencer
  import init_seq_pkg::*;
#(
  parameter int unsigned        NUM_CH         = 4,
  parameter int unsigned        SYNC_STAGES    = 2,
  parameter int unsigned        STABLE_CYCLES  = 16,
  parameter int unsigned        RELEASE_GAP    = 8,
  parameter int unsigned        TIMEOUT_CYCLES = 1000000,
  parameter logic [NUM_CH-1:0]  REQ_MASK       = '1
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic [NUM_CH-1:0] INIT_DONE,
  input  logic              CLR_ERR,
  output logic [NUM_CH-1:0] CH_RESET_N,
  output logic              ALL_DONE,
  output logic              TIMEOUT_ERR,
  output logic              DONE_LOST
);

  localparam int unsigned       IdxW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IdxW-1:0]   LastIdx     = IdxW'(NUM_CH - 1);
  localparam logic [CntW-1:0]   GapLast     = CntW'(RELEASE_GAP - 1);
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_CH-1:0] ChOne       = NUM_CH'(1);

  logic [NUM_CH-1:0] synced, stable;
  logic              all_stable, req_low;

  seq_state_e        state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [CntW-1:0]   gap_q, gap_d;
  logic [IdxW-1:0]   idx_q, idx_d, next_idx;
  logic              stable_q, stable_d;
  logic [NUM_CH-1:0] ch_rst_q, ch_rst_d;
  logic              all_done_q, all_done_d;
  logic              to_err_q, to_err_d, lost_q, lost_d;
  logic              to_set, lost_set;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_filter
    init_done_filter #(
      .SYNC_STAGES   (SYNC_STAGES),
      .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
      .clk       (CLK),
      .rst_n     (RESETN),
      .init_done (INIT_DONE[i]),
      .synced    (synced[i]),
      .stable    (stable[i])
    );
  end

  // Non-required channels are forced stable and never count as dropped
  assign all_stable = &(stable | ~REQ_MASK);
  assign req_low    = |(~synced & REQ_MASK);
  assign next_idx   = idx_q + 1'b1;

  // Next-state, release sequencing and sticky flag logic
  always_comb begin
    state_d  = state_q;
    timer_d  = '0;
    gap_d    = gap_q;
    idx_d    = idx_q;
    ch_rst_d = ch_rst_q;
    to_set   = 1'b0;
    lost_set = 1'b0;
    // Only a stability seen while already waiting may trigger a release
    stable_d = all_stable && (state_q == StWaitInit);

    unique case (state_q)
      StWaitInit: begin
        ch_rst_d = '0;
        timer_d  = (timer_q != '1) ? timer_q + 1'b1 : timer_q;
        if (stable_q) begin
          ch_rst_d = ChOne;
          gap_d    = '0;
          idx_d    = '0;
          state_d  = (NUM_CH == 1) ? StRun : StRelease;
        end else if ((TIMEOUT_CYCLES != 0) && (timer_q == TimeoutLast)) begin
          to_set  = 1'b1;
          state_d = StFault;
        end
      end
      StRelease: begin
        if (req_low) begin
          lost_set = 1'b1;
          ch_rst_d = '0;
          state_d  = StWaitInit;
        end else if (gap_q == GapLast) begin
          gap_d    = '0;
          idx_d    = next_idx;
          ch_rst_d = ch_rst_q | (ChOne << next_idx);
          if (next_idx == LastIdx) state_d = StRun;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StRun: begin
        if (req_low) begin
          lost_set = 1'b1;
          ch_rst_d = '0;
          state_d  = StWaitInit;
        end
      end
      StFault: begin
        ch_rst_d = '0;
        if (CLR_ERR) state_d = StWaitInit;
      end
    endcase

    all_done_d = (state_d == StRun);
    // A set event in the same cycle overrides the clear
    to_err_d   = to_set | (to_err_q & ~CLR_ERR);
    lost_d     = lost_set | (lost_q & ~CLR_ERR);
  end

  // State and registered outputs
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= StWaitInit;
      timer_q    <= '0;
      gap_q      <= '0;
      idx_q      <= '0;
      stable_q   <= 1'b0;
      ch_rst_q   <= '0;
      all_done_q <= 1'b0;
      to_err_q   <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      gap_q      <= gap_d;
      idx_q      <= idx_d;
      stable_q   <= stable_d;
      ch_rst_q   <= ch_rst_d;
      all_done_q <= all_done_d;
      to_err_q   <= to_err_d;
      lost_q     <= lost_d;
    end
  end

  assign CH_RESET_N  = ch_rst_q;
  assign ALL_DONE    = all_done_q;
  assign TIMEOUT_ERR = to_err_q;
  assign DONE_LOST   = lost_q;

endmodule

// File: tb/tb_init_reset_sequencer.sv
// Directed, table-driven bench for init_reset_sequencer.
module tb_init_reset_sequencer;

  logic       clk = 1'b0;
  logic       rstn_a = 1'b0, rstn_b = 1'b0;
  logic [3:0] init_a = '0, init_b = '0;
  logic       clr_a = 1'b0, clr_b = 1'b0;
  logic [3:0] rst_a, rst_b;
  logic       done_a, done_b, to_a, to_b, lost_a, lost_b;

  int unsigned ecnt   = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  init_reset_sequencer #(
    .NUM_CH(4), .SYNC_STAGES(2), .STABLE_CYCLES(4), .RELEASE_GAP(2),
    .TIMEOUT_CYCLES(100), .REQ_MASK(4'b1111)
  ) u_dut_a (
    .CLK(clk), .RESETN(rstn_a), .INIT_DONE(init_a), .CLR_ERR(clr_a),
    .CH_RESET_N(rst_a), .ALL_DONE(done_a), .TIMEOUT_ERR(to_a), .DONE_LOST(lost_a)
  );

  init_reset_sequencer #(
    .NUM_CH(4), .SYNC_STAGES(2), .STABLE_CYCLES(4), .RELEASE_GAP(2),
    .TIMEOUT_CYCLES(100), .REQ_MASK(4'b0111)
  ) u_dut_b (
    .CLK(clk), .RESETN(rstn_b), .INIT_DONE(init_b), .CLR_ERR(clr_b),
    .CH_RESET_N(rst_b), .ALL_DONE(done_b), .TIMEOUT_ERR(to_b), .DONE_LOST(lost_b)
  );

  typedef struct {
    int unsigned at_edge;  // 0 = reset, then start a scenario with these inputs
    bit          sel;      // 0 = unmasked DUT, 1 = DUT with channel 3 not required
    logic [3:0]  init;     // inputs applied after the check
    logic        clr;
    logic [3:0]  e_rst;
    logic        e_done;
    logic        e_to;
    logic        e_lost;
  } vec_t;

  vec_t vecs[$];

  // Advance one edge and settle past it
  task automatic tick();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  task automatic chk(input string name, input bit sel, input logic [3:0] e_rst,
                     input logic e_done, input logic e_to, input logic e_lost);
    logic [6:0] got, exp;
    got = sel ? {rst_b, done_b, to_b, lost_b} : {rst_a, done_a, to_a, lost_a};
    exp = {e_rst, e_done, e_to, e_lost};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: {rst,done,to,lost} got %b required %b", name, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic [3:0] init, input logic clr);
    if (sel) begin init_b = init; clr_b = clr; end
    else     begin init_a = init; clr_a = clr; end
  endtask

  // Hold reset for two edges, check cleared outputs, release just after edge 0
  task automatic start(input bit sel, input logic [3:0] init, input logic clr);
    if (sel) rstn_b = 1'b0; else rstn_a = 1'b0;
    drive(sel, 4'b0000, 1'b0);
    tick();
    tick();
    chk("reset_state", sel, 4'b0000, 1'b0, 1'b0, 1'b0);
    ecnt = 0;
    if (sel) rstn_b = 1'b1; else rstn_a = 1'b1;
    drive(sel, init, clr);
  endtask

  initial begin
    // Nominal release, required-done drop, re-sequence, error clear
    vecs.push_back('{0,  0, 4'b1111, 0, 4'b0000, 0, 0, 0});
    vecs.push_back('{7,  0, 4'b1111, 0, 4'b0000, 0, 0, 0});
    vecs.push_back('{8,  0, 4'b1111, 0, 4'b0001, 0, 0, 0});
    vecs.push_back('{9,  0, 4'b1111, 0, 4'b0001, 0, 0, 0});
    vecs.push_back('{10, 0, 4'b1111, 0, 4'b0011, 0, 0, 0});
    vecs.push_back('{12, 0, 4'b1111, 0, 4'b0111, 0, 0, 0});
    vecs.push_back('{13, 0, 4'b1111, 0, 4'b0111, 0, 0, 0});
    vecs.push_back('{14, 0, 4'b1111, 0, 4'b1111, 1, 0, 0});
    vecs.push_back('{20, 0, 4'b1101, 0, 4'b1111, 1, 0, 0});
    vecs.push_back('{22, 0, 4'b1101, 0, 4'b1111, 1, 0, 0});
    vecs.push_back('{23, 0, 4'b1101, 0, 4'b0000, 0, 0, 1});
    vecs.push_back('{25, 0, 4'b1111, 0, 4'b0000, 0, 0, 1});
    vecs.push_back('{32, 0, 4'b1111, 0, 4'b0000, 0, 0, 1});
    vecs.push_back('{33, 0, 4'b1111, 0, 4'b0001, 0, 0, 1});
    vecs.push_back('{35, 0, 4'b1111, 0, 4'b0011, 0, 0, 1});
    vecs.push_back('{39, 0, 4'b1111, 1, 4'b1111, 1, 0, 1});
    vecs.push_back('{40, 0, 4'b1111, 0, 4'b1111, 1, 0, 0});
    // Short glitch on channel 2 only, then timeout, fault, clear, recover
    vecs.push_back('{0,   0, 4'b0000, 0, 4'b0000, 0, 0, 0});
    vecs.push_back('{2,   0, 4'b0100, 0, 4'b0000, 0, 0, 0});
    vecs.push_back('{5,   0, 4'b0000, 0, 4'b0000, 0, 0, 0});
    vecs.push_back('{99,  0, 4'b0000, 0, 4'b0000, 0, 0, 0});
    vecs.push_back('{100, 0, 4'b0000, 0, 4'b0000, 0, 1, 0});
    vecs.push_back('{110, 0, 4'b0000, 1, 4'b0000, 0, 1, 0});
    vecs.push_back('{111, 0, 4'b1111, 0, 4'b0000, 0, 0, 0});
    vecs.push_back('{118, 0, 4'b1111, 0, 4'b0000, 0, 0, 0});
    vecs.push_back('{119, 0, 4'b1111, 0, 4'b0001, 0, 0, 0});
    // Channel 3 not required: released anyway, its drop is ignored
    vecs.push_back('{0,  1, 4'b0111, 0, 4'b0000, 0, 0, 0});
    vecs.push_back('{7,  1, 4'b0111, 0, 4'b0000, 0, 0, 0});
    vecs.push_back('{8,  1, 4'b0111, 0, 4'b0001, 0, 0, 0});
    vecs.push_back('{10, 1, 4'b0111, 0, 4'b0011, 0, 0, 0});
    vecs.push_back('{14, 1, 4'b1111, 0, 4'b1111, 1, 0, 0});
    vecs.push_back('{20, 1, 4'b0111, 0, 4'b1111, 1, 0, 0});
    vecs.push_back('{26, 1, 4'b0111, 0, 4'b1111, 1, 0, 0});

    tick();
    foreach (vecs[i]) begin
      if (vecs[i].at_edge == 0) begin
        start(vecs[i].sel, vecs[i].init, vecs[i].clr);
      end else begin
        while (ecnt < vecs[i].at_edge) tick();
        chk($sformatf("vec%0d@%0d", i, vecs[i].at_edge), vecs[i].sel, vecs[i].e_rst,
            vecs[i].e_done, vecs[i].e_to, vecs[i].e_lost);
        drive(vecs[i].sel, vecs[i].init, vecs[i].clr);
      end
    end

    // Reset pulse during release after channel 1 is out of reset
    start(1'b0, 4'b1111, 1'b0);
    while (ecnt < 10) tick();
    chk("mid_release", 1'b0, 4'b0011, 1'b0, 1'b0, 1'b0);
    tick();
    rstn_a = 1'b0;
    #1;
    chk("async_clear", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    chk("reset_held", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    ecnt   = 0;
    rstn_a = 1'b1;
    while (ecnt < 7) tick();
    chk("restart_e7", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    chk("restart_e8", 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
    while (ecnt < 14) tick();
    chk("restart_e14", 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/init_reset_sequencer.md
INIT_RESET_SEQUENCER -- requirements
Module: init_reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of init-done channels (1..8).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth per channel (2..3).
REQ-003 SHALL have parameter STABLE_CYCLES, default 16, consecutive synced-high cycles before a channel counts as done (1..65535).
REQ-004 SHALL have parameter RELEASE_GAP, default 8, cycles between successive channel reset releases (1..65535).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1000000, init wait limit; 0 disables the timeout.
REQ-006 SHALL have parameter REQ_MASK, default all ones (NUM_CH bits); a 1 marks a channel whose done is required.
REQ-007 SHALL have port CLK, input, 1, the single clock.
REQ-008 SHALL have port RESETN, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port INIT_DONE, input, NUM_CH, asynchronous init-done flags (e.g. fabric POR, USRAM, SRAM, XCVR).
REQ-010 SHALL have port CLR_ERR, input, 1, synchronous single-cycle error clear.
REQ-011 SHALL have port CH_RESET_N, output, NUM_CH, per-channel active-low resets.
REQ-012 SHALL have port ALL_DONE, output, 1, high while the sequencer is in RUN.
REQ-013 SHALL have port TIMEOUT_ERR, output, 1, sticky init timeout flag.
REQ-014 SHALL have port DONE_LOST, output, 1, sticky flag set when a required done drops in RUN.

Function
REQ-015 SHALL pass each INIT_DONE bit through SYNC_STAGES flops before any use.
REQ-016 SHALL keep a per-channel stability counter: it clears on a synced-low cycle, increments on a synced-high cycle, and saturates at STABLE_CYCLES; the channel is stable when the counter equals STABLE_CYCLES.
REQ-017 SHALL implement FSM states WAIT_INIT, RELEASE, RUN and FAULT; WAIT_INIT is the reset state.
REQ-018 WAIT_INIT: all CH_RESET_N low; the timer increments every cycle; go to RELEASE on the cycle after all REQ_MASK channels are stable.
REQ-019 WAIT_INIT: if TIMEOUT_CYCLES is non-zero and the timer reaches TIMEOUT_CYCLES before release, go to FAULT and set TIMEOUT_ERR; if both conditions hit on the same cycle, RELEASE wins.
REQ-020 RELEASE: drive CH_RESET_N[0] high on entry, then CH_RESET_N[i+1] exactly RELEASE_GAP cycles after CH_RESET_N[i], in ascending order for all channels, including non-required ones.
REQ-021 Released channels SHALL stay high; after the last channel releases, move to RUN on that same cycle's transition, with ALL_DONE high in the same cycle as CH_RESET_N[NUM_CH-1].
REQ-022 Latency: with all INIT_DONE rising at edge 0, CH_RESET_N[0] SHALL rise at edge SYNC_STAGES+STABLE_CYCLES+2.
REQ-023 RELEASE/RUN: if any required channel's synced done goes low, drive all CH_RESET_N low and ALL_DONE low on the next edge, set DONE_LOST, clear the timer and enter WAIT_INIT.
REQ-024 FAULT: all CH_RESET_N low; leave only on CLR_ERR, going to WAIT_INIT with the timer cleared.
REQ-025 CLR_ERR SHALL clear TIMEOUT_ERR and DONE_LOST in any state; a simultaneous set event SHALL win over the clear.
REQ-026 Non-required channels SHALL never affect state transitions.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 RESETN low SHALL asynchronously clear synchronisers, counters, timer, TIMEOUT_ERR, DONE_LOST, ALL_DONE and CH_RESET_N (all 0), and set the FSM to WAIT_INIT.
REQ-029 Reset deassertion mid-sequence SHALL restart from WAIT_INIT with no partial release retained.

Structure
REQ-030 SHALL place the FSM state enum and the counter width constant (16-bit stability/gap, 32-bit timer) in shared package init_seq_pkg.
REQ-031 SHALL instantiate one sub-module per channel, init_done_filter, containing the synchroniser and stability counter.

Verification (NUM_CH=4, SYNC_STAGES=2, STABLE_CYCLES=4, RELEASE_GAP=2, TIMEOUT_CYCLES=100)
REQ-032 All INIT_DONE rise at edge 0 -> CH_RESET_N[0..3] rise at edges 8, 10, 12, 14; ALL_DONE at 14.
REQ-033 INIT_DONE[2] glitches high 3 cycles then low, then stays low -> no release; TIMEOUT_ERR=1 at edge 100; FAULT; CLR_ERR returns to WAIT_INIT.
REQ-034 In RUN, drop INIT_DONE[1] -> all CH_RESET_N and ALL_DONE low 3 edges later (2 sync + 1); DONE_LOST=1; re-raising INIT_DONE[1] re-sequences.
REQ-035 REQ_MASK=4'b0111, INIT_DONE[3] held low -> sequence completes per REQ-032; dropping INIT_DONE[3] in RUN causes no change.
REQ-036 RESETN pulsed low during RELEASE after CH_RESET_N[1] rises -> all outputs 0 immediately; full sequence restarts after deassertion.
